// File: rtl/prbs_pkg.sv
// rtl/prbs_pkg.sv - PRBS9 (x^9 + x^5 + 1) constants, state type and next-state function
// Shared between the prbs9 generator and the matching checker.
package prbs_pkg;

  localparam int PRBS9_LEN    = 9;
  localparam int PRBS9_TAP    = 4;
  localparam int PRBS9_PERIOD = 511;

  typedef logic [PRBS9_LEN-1:0] prbs9_state_t;

  // Shift left; the new LSB is the XOR of the outgoing MSB and the x^5 tap.
  function automatic prbs9_state_t prbs9_next(input prbs9_state_t s);
    return {s[PRBS9_LEN-2:0], s[PRBS9_LEN-1] ^ s[PRBS9_TAP]};
  endfunction

endpackage

// File: rtl/prbs9_gen.sv
// rtl/prbs9_gen.sv - serial PRBS9 test-pattern generator, one bit per enabled clock
// Optional macro PRBS9_ZERO_GUARD_EN: recover from the all-zero state instead of locking up.
module prbs9_gen
  import prbs_pkg::*;
#(
  parameter prbs9_state_t SEED = 9'h1AA
) (
  input  logic clock,
  input  logic i_reset,
  input  logic i_enable,
  output logic o_bit
);

  prbs9_state_t r;
  prbs9_state_t r_next;

  always_comb begin
    r_next = prbs9_next(r);
`ifdef PRBS9_ZERO_GUARD_EN
    // All-zero is a fixed point of the LFSR; restart from the seed (or all-ones if the seed is zero).
    if (r == '0) begin
      r_next = (SEED == '0) ? 9'h1FF : SEED;
    end
`endif
  end

  always_ff @(posedge clock or posedge i_reset) begin
    if (i_reset) begin
      r <= SEED;
    end else if (i_enable) begin
      r <= r_next;
    end
  end

  assign o_bit = r[PRBS9_LEN-1];

endmodule

// File: tb/tb_prbs9_gen.sv
// tb/tb_prbs9_gen.sv - self-checking bench for prbs9_gen against a recurrence-based bit model
// Optional macro PRBS9_ZERO_GUARD_EN selects the guarded expectation for the zero-seed instance.
module tb_prbs9_gen;
  import prbs_pkg::*;

  logic clock;
  logic rst;
  logic en0, en1, en2;
  logic bit0, bit1, bit2;

  int checks = 0;
  int errors = 0;

  prbs9_gen #(.SEED(9'h1AA)) dut0 (.clock(clock), .i_reset(rst), .i_enable(en0), .o_bit(bit0));
  prbs9_gen #(.SEED(9'h001)) dut1 (.clock(clock), .i_reset(rst), .i_enable(en1), .o_bit(bit1));
  prbs9_gen #(.SEED(9'h000)) dut2 (.clock(clock), .i_reset(rst), .i_enable(en2), .o_bit(bit2));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic en;
    logic exp_bit;
  } vec_t;

  vec_t tbl [16];

  logic [1021:0] ga, gb, gz;

  // Output stream model: first nine bits are the seed MSB-first, then b[n+9] = b[n] ^ b[n+4].
  function automatic logic [1021:0] build(input logic [8:0] s);
    logic [1021:0] g;
    g = '0;
    for (int i = 0; i < 9; i++) g[i] = s[8-i];
    for (int i = 9; i < 1022; i++) g[i] = g[i-9] ^ g[i-5];
    return g;
  endfunction

  task automatic chk(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0b expected %0b", name, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    @(negedge clock);
  endtask

  initial begin
    int n;
    int ones;
    logic [8:0] first9;
    logic [8:0] exp9;

    ga = build(9'h1AA);
    gb = build(9'h001);
    gz = build(9'h1FF);

    tbl[0]  = '{1'b1, 1'b1};
    tbl[1]  = '{1'b1, 1'b0};
    tbl[2]  = '{1'b0, 1'b0};
    tbl[3]  = '{1'b0, 1'b0};
    tbl[4]  = '{1'b1, 1'b1};
    tbl[5]  = '{1'b1, 1'b0};
    tbl[6]  = '{1'b1, 1'b1};
    tbl[7]  = '{1'b1, 1'b0};
    tbl[8]  = '{1'b1, 1'b1};
    tbl[9]  = '{1'b1, 1'b0};
    tbl[10] = '{1'b1, 1'b1};
    tbl[11] = '{1'b0, 1'b1};
    tbl[12] = '{1'b1, 1'b0};
    tbl[13] = '{1'b1, 1'b0};
    tbl[14] = '{1'b1, 1'b0};
    tbl[15] = '{1'b1, 1'b0};

    rst = 1'b1; en0 = 1'b0; en1 = 1'b0; en2 = 1'b0;
    step();
    step();
    chk("reset_bit_1aa", bit0, 1'b1);
    chk("reset_bit_001", bit1, 1'b0);
    chk("reset_bit_000", bit2, 1'b0);
    rst = 1'b0;

    // Table-driven start of the 1AA stream with interleaved holds.
    chk("b0_after_release", bit0, 1'b1);
    for (int i = 0; i < 16; i++) begin
      en0 = tbl[i].en;
      step();
      chk($sformatf("table_%0d", i), bit0, tbl[i].exp_bit);
    end
    n = 13;

    // Free run through two full periods against the golden vector; count ones over one period.
    en0 = 1'b1;
    ones = 0;
    while (n < 1021) begin
      step();
      n++;
      chk($sformatf("golden_%0d", n), bit0, ga[n]);
      if (n >= 14 && n < 14 + PRBS9_PERIOD) ones += int'(bit0);
    end
    chk_int("ones_per_period", ones, 256);
    chk_int("golden_periodic", int'(ga[520:512] == ga[9:1]), 1);

    // Enable low for 5 cycles: output frozen, then resumes with no skip.
    en0 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("hold_frozen", bit0, ga[n % PRBS9_PERIOD]);
    end
    en0 = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      n++;
      chk("resume", bit0, ga[n % PRBS9_PERIOD]);
    end

    // Randomized enable against the model position.
    for (int i = 0; i < 300; i++) begin
      en0 = 1'($urandom_range(0, 1));
      step();
      if (en0) n++;
      chk("random_en", bit0, ga[n % PRBS9_PERIOD]);
    end

    // Mid-run async reset: immediate reload, stream restarts at b[0].
    en0 = 1'b1;
    rst = 1'b1;
    #1;
    chk("async_reset_immediate", bit0, 1'b1);
    @(negedge clock);
    chk("reset_held", bit0, 1'b1);
    rst = 1'b0;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      n++;
      chk("restart", bit0, ga[n]);
    end
    en0 = 1'b0;

    // SEED = 001: literal first nine bits, then two periods against the model.
    exp9 = 9'b000000001;
    first9 = '0;
    en1 = 1'b1;
    first9[8] = bit1;
    for (int i = 1; i < 9; i++) begin
      step();
      first9[8-i] = bit1;
    end
    chk_int("seed001_first9", int'(first9), int'(exp9));
    n = 8;
    while (n < 1021) begin
      step();
      n++;
      chk($sformatf("seed001_%0d", n), bit1, gb[n]);
    end
    en1 = 1'b0;

    // SEED = 0: locks at zero unless the guard is built in.
    en2 = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      step();
`ifdef PRBS9_ZERO_GUARD_EN
      chk("zero_seed", bit2, gz[k-1]);
`else
      chk("zero_seed", bit2, 1'b0);
`endif
    end
    en2 = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
